// File: rtl/washer_pkg.sv
// Shared definitions for the washer-bank control slice: arbiter state
// encodings and an index-width helper.
package washer_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OPEN = 2'd1,
      ARB_GAP  = 2'd2
   } arb_state_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request bit scanning from ptr
// upward, wrapping at N_REQ-1 back to 0.
module rr_priority_pick
   import washer_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   logic [31:0]      base;
   logic [IDX_W-1:0] pos;

   // Scan from the farthest slot down so the slot nearest ptr is written last.
   always_comb begin
      base = 32'(ptr);
      any  = |req;
      idx  = '0;
      pos  = '0;
      for (int unsigned k = N_REQ; k > 0; k--) begin
         pos = IDX_W'((base + k - 1) % N_REQ);
         if (req[pos]) idx = pos;
      end
   end

endmodule

// File: rtl/fill_valve_arbiter.sv
// Round-robin arbiter sharing one inlet valve among N_REQ washers, with a
// per-grant watchdog and a valve-settle gap between grants.
module fill_valve_arbiter
   import washer_pkg::*;
#(
   parameter int unsigned      N_REQ            = 4,
   parameter int unsigned      CNT_W            = 32,
   parameter logic [CNT_W-1:0] MAX_GRANT_CYCLES = CNT_W'(120000000),
   parameter int unsigned      GAP_CYCLES       = 16
) (
   input  logic                          clk_top,
   input  logic                          reset,
   input  logic [N_REQ-1:0]              fill_req,
   input  logic [N_REQ-1:0]              fill_done,
   input  logic                          pause,
   output logic [N_REQ-1:0]              grant,
   output logic [idx_width(N_REQ)-1:0]   grant_id,
   output logic                          valve_open,
   output logic                          busy,
   output logic                          timeout_pulse
);

   localparam int unsigned      IDX_W     = idx_width(N_REQ);
   localparam logic [CNT_W-1:0] HOLD_LAST = MAX_GRANT_CYCLES - CNT_W'(1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES) - CNT_W'(1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

   arb_state_t       state, state_nx;
   logic [N_REQ-1:0] grant_nx;
   logic [IDX_W-1:0] id_nx, rr_ptr, ptr_nx, pick_idx;
   logic             valve_nx, busy_nx, tp_nx, pick_any;
   logic [CNT_W-1:0] hold_cnt, hold_nx, gap_cnt, gap_nx;
   logic             normal_rel, expire;

   rr_priority_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req (fill_req),
      .ptr (rr_ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_ff @(posedge clk_top or negedge reset) begin
      if (!reset) begin
         state         <= ARB_IDLE;
         grant         <= '0;
         grant_id      <= '0;
         valve_open    <= 1'b0;
         busy          <= 1'b0;
         timeout_pulse <= 1'b0;
         rr_ptr        <= '0;
         hold_cnt      <= '0;
         gap_cnt       <= '0;
      end else begin
         state         <= state_nx;
         grant         <= grant_nx;
         grant_id      <= id_nx;
         valve_open    <= valve_nx;
         busy          <= busy_nx;
         timeout_pulse <= tp_nx;
         rr_ptr        <= ptr_nx;
         hold_cnt      <= hold_nx;
         gap_cnt       <= gap_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      grant_nx   = grant;
      id_nx      = grant_id;
      valve_nx   = valve_open;
      busy_nx    = busy;
      tp_nx      = 1'b0;
      ptr_nx     = rr_ptr;
      hold_nx    = hold_cnt;
      gap_nx     = gap_cnt;
      normal_rel = 1'b0;
      expire     = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (pick_any) begin
               state_nx           = ARB_OPEN;
               grant_nx           = '0;
               grant_nx[pick_idx] = 1'b1;
               id_nx              = pick_idx;
               valve_nx           = 1'b1;
               busy_nx            = 1'b1;
               hold_nx            = '0;
               ptr_nx             = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_W'(1);
            end
         end
         ARB_OPEN: begin
            // A normal release wins over a coincident watchdog expiry.
            normal_rel = fill_done[grant_id] || !fill_req[grant_id];
            expire     = (hold_cnt == HOLD_LAST) && !pause;
            if (normal_rel || expire) begin
               grant_nx = '0;
               valve_nx = 1'b0;
               gap_nx   = '0;
               tp_nx    = !normal_rel;
               if (GAP_CYCLES == 0) begin
                  state_nx = ARB_IDLE;
                  busy_nx  = 1'b0;
               end else begin
                  state_nx = ARB_GAP;
               end
            end else if (!pause) begin
               hold_nx = hold_cnt + CNT_W'(1);
            end
         end
         ARB_GAP: begin
            gap_nx = gap_cnt + CNT_W'(1);
            if (gap_cnt == GAP_LAST) begin
               state_nx = ARB_IDLE;
               busy_nx  = 1'b0;
            end
         end
         default: state_nx = ARB_IDLE;
      endcase
   end

endmodule

// File: tb/tb_fill_valve_arbiter.sv
// Self-checking bench for fill_valve_arbiter: directed scenarios plus random
// washer traffic, compared every cycle against a behavioural valve model.
module tb_fill_valve_arbiter;

   localparam int MAX_G = 8;
   localparam int GAP   = 2;

   logic       clk_top = 1'b0;
   logic       reset   = 1'b0;
   logic [3:0] fill_req = '0, fill_done = '0;
   logic       pause = 1'b0;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic       valve_open, busy, timeout_pulse;

   int n_checks = 0;
   int n_errors = 0;

   // Model: who holds the valve (-1 none), unpaused cycles held, gap cycles left.
   int m_owner = -1, m_held = 0, m_gap = 0, m_ptr = 0, m_id = 0;
   bit m_tp = 1'b0;

   fill_valve_arbiter #(
      .N_REQ            (4),
      .CNT_W            (32),
      .MAX_GRANT_CYCLES (32'd8),
      .GAP_CYCLES       (2)
   ) dut (
      .clk_top       (clk_top),
      .reset         (reset),
      .fill_req      (fill_req),
      .fill_done     (fill_done),
      .pause         (pause),
      .grant         (grant),
      .grant_id      (grant_id),
      .valve_open    (valve_open),
      .busy          (busy),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clk_top = ~clk_top;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit done_ev, to_ev;
      m_tp = 1'b0;
      if (!reset) begin
         m_owner = -1; m_held = 0; m_gap = 0; m_ptr = 0; m_id = 0;
      end else if (m_owner >= 0) begin
         done_ev = fill_done[m_owner] || !fill_req[m_owner];
         to_ev   = (m_held == MAX_G - 1) && !pause;
         if (done_ev || to_ev) begin
            m_tp    = !done_ev;
            m_owner = -1;
            m_gap   = GAP;
         end else if (!pause) begin
            m_held++;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else if (fill_req != 0) begin
         for (int k = 0; k < 4; k++) begin
            if (m_owner < 0 && fill_req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
         end
         m_id   = m_owner;
         m_held = 0;
         m_ptr  = (m_owner + 1) % 4;
      end
   endtask

   task automatic compare_all();
      logic [31:0] eg;
      eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
      check_val("grant", 32'(grant), eg);
      check_val("grant_id", 32'(grant_id), 32'(m_id));
      check_val("valve_open", 32'(valve_open), 32'(m_owner >= 0));
      check_val("busy", 32'(busy), 32'(m_owner >= 0 || m_gap > 0));
      check_val("timeout_pulse", 32'(timeout_pulse), 32'(m_tp));
   endtask

   // Called at a negedge: drive, advance one edge, model, check, return at negedge.
   task automatic step(input logic [3:0] r, input logic [3:0] d, input logic p);
      fill_req  = r;
      fill_done = d;
      pause     = p;
      @(posedge clk_top);
      model_edge();
      #1;
      compare_all();
      @(negedge clk_top);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'b0000, 4'b0000, 1'b0);
   endtask

   // Runs one grant to its release and on to the next grant's rise.
   task automatic run_grant(input logic [3:0] r, input int p_lo, input int p_hi,
                            input bit gap_pause, input bit done_late,
                            output int len, output int tpc, output int low,
                            output logic [1:0] id_fall);
      int   phase;
      logic p;
      logic [3:0] d;
      phase = 0; len = 0; tpc = 0; low = 0; id_fall = '1;
      for (int i = 0; i < 60; i++) begin
         p = (phase == 1 && len >= p_lo && len < p_hi) || (phase == 2 && gap_pause);
         d = done_late ? ((phase == 1 && m_held == MAX_G - 1) ? 4'b1111 : 4'b1011) : 4'b0000;
         step(r, d, p);
         tpc += int'(timeout_pulse);
         if (phase == 0 && grant != 0) phase = 1;
         if (phase == 1) begin
            if (grant != 0) len++;
            else begin phase = 2; id_fall = grant_id; end
         end
         if (phase == 2) begin
            if (grant != 0) break;
            low++;
         end
      end
   endtask

   int         len, tpc, low, rises;
   logic [1:0] idf;
   logic [3:0] prevg, d, r;
   int         order[$];
   int         exp_order[5] = '{0, 1, 2, 3, 0};

   initial begin
      @(negedge clk_top);
      // 1: reset with random inputs, then single request from washer 2
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(4'($urandom), 4'($urandom), 1'($urandom));
         check_val("rst_grant", 32'(grant), 32'd0);
         check_val("rst_valve", 32'(valve_open), 32'd0);
         check_val("rst_busy", 32'(busy), 32'd0);
      end
      reset = 1'b1;
      step(4'b0100, 4'b0000, 1'b0);
      check_val("first_grant", 32'(grant), 32'h4);
      check_val("first_id", 32'(grant_id), 32'd2);

      // 2: all washers requesting, each finishes after 3 cycles
      reset = 1'b0;
      step(4'b0000, 4'b0000, 1'b0);
      reset = 1'b1;
      prevg = '0; low = 0; rises = 0;
      for (int i = 0; i < 80 && rises < 5; i++) begin
         d = (m_owner >= 0 && m_held == 3) ? 4'(1 << m_owner) : 4'b0000;
         step(4'b1111, d, 1'b0);
         if (grant != 0 && prevg == 0) begin
            order.push_back(int'(grant_id));
            if (rises > 0) check_val("rr_low_gap", 32'(low), 32'd3);
            rises++;
            low = 0;
         end
         if (grant == 0) low++;
         prevg = grant;
      end
      check_val("rr_rises", 32'(rises), 32'd5);
      foreach (order[i]) if (i < 5) check_val("rr_order", 32'(order[i]), 32'(exp_order[i]));
      idle(6);

      // 3: watchdog expiry
      run_grant(4'b0001, 0, 0, 1'b0, 1'b0, len, tpc, low, idf);
      check_val("to_len", 32'(len), 32'd8);
      check_val("to_pulses", 32'(tpc), 32'd1);
      check_val("to_id_kept", 32'(idf), 32'd0);
      check_val("to_low", 32'(low), 32'd3);
      idle(6);

      // 4: pause stretches the grant, not the gap
      run_grant(4'b0010, 2, 7, 1'b1, 1'b0, len, tpc, low, idf);
      check_val("pause_len", 32'(len), 32'd13);
      check_val("pause_gap", 32'(low), 32'd3);
      check_val("pause_pulses", 32'(tpc), 32'd1);
      idle(6);

      // 5: owner done coincides with expiry; non-owner done ignored
      run_grant(4'b0100, 0, 0, 1'b0, 1'b1, len, tpc, low, idf);
      check_val("coinc_len", 32'(len), 32'd8);
      check_val("coinc_pulses", 32'(tpc), 32'd0);
      idle(6);

      // 6: asynchronous reset mid-grant
      step(4'b0001, 4'b0000, 1'b0);
      step(4'b0001, 4'b0000, 1'b0);
      check_val("pre_rst_valve", 32'(valve_open), 32'd1);
      #2 reset = 1'b0;
      #1;
      check_val("async_valve", 32'(valve_open), 32'd0);
      check_val("async_grant", 32'(grant), 32'd0);
      @(negedge clk_top);
      step(4'b0001, 4'b0000, 1'b0);
      reset = 1'b1;
      step(4'b1000, 4'b0000, 1'b0);
      check_val("post_rst_grant", 32'(grant), 32'h8);
      check_val("post_rst_id", 32'(grant_id), 32'd3);
      idle(6);

      // Random washer traffic
      r = '0;
      for (int i = 0; i < 1500; i++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            d[b] = ($urandom_range(0, 7) == 0);
         end
         step(r, d, $urandom_range(0, 4) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
